// File: rtl/cb_exec.sv
// Executes one CB-prefixed rotate/shift/bit/res/set operation on a register or on memory at HL.
// Register ops finish the cycle after start; (HL) ops run a read and, except for BIT, a write-back.
module cb_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] hl,
  input  logic [3:0]  flags_in,
  output logic [2:0]  reg_sel,
  input  logic [7:0]  reg_rdata,
  output logic        reg_we,
  output logic [7:0]  reg_wdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  flags_out,
  output logic        flags_we,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t      state, state_nxt;
  logic [7:0]  op_q;
  logic [7:0]  operand_q;
  logic [15:0] hl_q;
  logic [3:0]  flags_q;
  logic [7:0]  res;
  logic [3:0]  res_flags;
  logic        c_out;
  logic        is_mem;
  logic        is_bit;
  logic [2:0]  bit_n;

  assign is_mem = (op_q[2:0] == 3'd6);
  assign is_bit = (op_q[7:6] == 2'b01);
  assign bit_n  = op_q[5:3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand comes from the register file at start, or from memory on the read ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= 8'h00;
      operand_q <= 8'h00;
      hl_q      <= 16'h0000;
      flags_q   <= 4'h0;
    end else if (state == IDLE && start) begin
      op_q    <= opcode;
      hl_q    <= hl;
      flags_q <= flags_in;
      if (opcode[2:0] != 3'd6) operand_q <= reg_rdata;
    end else if (state == RD && mem_ack) begin
      operand_q <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (opcode[2:0] == 3'd6) ? RD : FIN;
      RD:   if (mem_ack) state_nxt = is_bit ? FIN : WR;
      WR:   if (mem_ack) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res       = operand_q;
    res_flags = flags_q;
    c_out     = 1'b0;
    case (op_q[7:6])
      2'b00: begin
        case (bit_n)
          3'd0: begin c_out = operand_q[7]; res = {operand_q[6:0], operand_q[7]}; end
          3'd1: begin c_out = operand_q[0]; res = {operand_q[0], operand_q[7:1]}; end
          3'd2: begin c_out = operand_q[7]; res = {operand_q[6:0], flags_q[0]}; end
          3'd3: begin c_out = operand_q[0]; res = {flags_q[0], operand_q[7:1]}; end
          3'd4: begin c_out = operand_q[7]; res = {operand_q[6:0], 1'b0}; end
          3'd5: begin c_out = operand_q[0]; res = {operand_q[7], operand_q[7:1]}; end
          3'd6: begin c_out = 1'b0;         res = {operand_q[3:0], operand_q[7:4]}; end
          default: begin c_out = operand_q[0]; res = {1'b0, operand_q[7:1]}; end
        endcase
        res_flags = {(res == 8'h00), 1'b0, 1'b0, c_out};
      end
      2'b01:   res_flags = {~operand_q[bit_n], 1'b0, 1'b1, flags_q[0]};
      2'b10:   res[bit_n] = 1'b0;
      default: res[bit_n] = 1'b1;
    endcase
  end

  // Data outputs are forced to zero outside the states that own them.
  always_comb begin
    reg_sel   = (state == IDLE) ? opcode[2:0] : op_q[2:0];
    reg_we    = 1'b0;
    reg_wdata = 8'h00;
    mem_addr  = 16'h0000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    flags_out = 4'h0;
    flags_we  = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      RD: begin
        mem_rd   = 1'b1;
        mem_addr = hl_q;
      end
      WR: begin
        mem_wr    = 1'b1;
        mem_addr  = hl_q;
        mem_wdata = res;
      end
      FIN: begin
        done      = 1'b1;
        flags_we  = 1'b1;
        flags_out = res_flags;
        reg_wdata = res;
        reg_we    = !is_mem && !is_bit;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cb_exec.md
CB_EXEC -- requirements
Module: cb_exec

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request to execute one CB-prefixed op; sampled only in IDLE.
REQ-005 opcode  in  8  CB second byte: opcode[7:3]=operation, opcode[2:0]=target (0-5,7 register; 6 = memory at HL).
REQ-006 hl  in  16  HL value, latched on accepted start.
REQ-007 flags_in  in  4  {Z,N,H,C}, latched on accepted start.
REQ-008 reg_sel  out  3  register-file read/write index.
REQ-009 reg_rdata  in  8  register-file read data for reg_sel, same cycle.
REQ-010 reg_we  out  1  register write strobe.
REQ-011 reg_wdata  out  8  register write data.
REQ-012 mem_addr  out  16  memory address.
REQ-013 mem_rd / mem_wr  out  1 each  read/write request, held until mem_ack.
REQ-014 mem_wdata  out  8  write data.
REQ-015 mem_rdata  in  8  read data, valid in the mem_ack cycle.
REQ-016 mem_ack  in  1  completes the current mem_rd or mem_wr.
REQ-017 flags_out  out  4  {Z,N,H,C} result; flags_we  out  1  flag write strobe.
REQ-018 busy  out  1  high in every state except IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-019 States: IDLE, RD, WR, FIN; encoding is free.
REQ-020 IDLE with start=1: latch opcode, hl, flags_in. Target!=6: latch reg_rdata as operand and go to FIN. Target=6: go to RD. In IDLE, reg_sel = opcode[2:0] (live input); in all other states, reg_sel = latched target.
REQ-021 IDLE with start=0: remain in IDLE.
REQ-022 RD: mem_rd=1, mem_addr=latched hl. On mem_ack, latch mem_rdata as operand. Then go to FIN if the op is BIT (opcode[7:6]=01), otherwise go to WR.
REQ-023 WR: mem_wr=1, mem_addr=latched hl, mem_wdata=result. On mem_ack go to FIN.
REQ-024 FIN: done=1 and flags_we=1 for exactly one cycle. reg_we=1 only when target!=6 and the op is not BIT. reg_wdata=result. Next state is IDLE.
REQ-025 The result is computed combinationally from the latched operand, opcode and flags. Rotate/shift ops set N=0 and H=0, and Z=(result==0). Ops:
- RLC/RRC: C = bit shifted out; that bit re-enters at the other end.
- RL/RR: C = bit shifted out; the old C enters.
- SLA: shifts in 0, C=in[7].
- SRA: keeps in[7], C=in[0].
- SWAP: exchanges nibbles, C=0.
- SRL: shifts in 0, C=in[0].
- BIT n: operand unchanged, Z=~in[n], N=0, H=1, C unchanged.
- RES/SET n: clear/set bit n, flags unchanged.
REQ-026 mem_rd and mem_wr are never high together. Both are 0 in IDLE and FIN.
REQ-027 start outside IDLE is ignored, with no effect on latched values.
REQ-028 Latency from the start cycle N:
- register op: FIN at N+1;
- memory BIT with immediate ack: FIN at N+2;
- memory read-modify-write with immediate acks: FIN at N+3;
- each ack wait cycle adds one cycle.
REQ-029 An ack arriving in IDLE or FIN is ignored.

Reset
REQ-030 While rst=1, and immediately on assertion (including mid-operation): state=IDLE; busy, done, reg_we, flags_we, mem_rd, mem_wr=0; reg_wdata, mem_wdata, flags_out, mem_addr, latched registers=0. Any pending memory transaction is abandoned.
REQ-031 The first start after rst deasserts is accepted normally.

Verification
REQ-032 opcode=0x00 (RLC B), B=0x80, flags_in=0000 -> done at N+1, reg_sel=0, reg_we=1, reg_wdata=0x01, flags_out=0001, no memory strobes.
REQ-033 opcode=0x36 (SWAP (HL)), hl=0xC000, mem_rdata=0x00, ack after 2 wait cycles on each access -> mem_rd then mem_wr at 0xC000, mem_wdata=0x00, flags_out=1000, done at N+7, reg_we=0.
REQ-034 opcode=0x7E (BIT 7,(HL)), mem_rdata=0x7F, flags_in=0001 -> one read only, no mem_wr, flags_out=1011, reg_we=0.
REQ-035 opcode=0xDF (SET 3,A), A=0x00, flags_in=1010 -> reg_sel=7, reg_wdata=0x08, flags_out=1010.
REQ-036 rst asserted during WR -> all outputs 0 in the same cycle, IDLE. A subsequent register op completes per REQ-032.
REQ-037 start pulsed during RD with a different opcode -> ignored; the original op completes unchanged.
